// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle stage controller for the RV32I core.
// Owns the word-addressed PC and issues one-cycle enable strobes to the
// fetch, decode, execute and write-back stages in strict order, inserting
// wait cycles for fetch latency and load/store memory latency.
//
// Optional feature macro: CORE_SEQ_PERF_EN
//   defined   -> cycle_count / retired_count are live 32-bit counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// All outputs come straight from flops, so there is no combinational path
// from any input to any output.

module core_sequencer #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned MEM_LAT   = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt_req,
    input  logic        exec_is_load,
    input  logic        exec_is_store,
    input  logic        exec_is_jump,
    input  logic [31:0] exec_jump_dest,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        write_en,
    output logic        busy,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    // Last value of the shared wait counter in each multi-cycle state.
    localparam logic [15:0] FETCH_LAST = 16'(FETCH_LAT - 1);
    localparam logic [15:0] MEM_LAST   = 16'(MEM_LAT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [15:0] r_wait;
    logic        r_halt;
    logic        r_jump_taken;
    logic [31:0] r_jump_dest;
    logic        r_fetch_en;
    logic        r_decode_en;
    logic        r_exec_en;
    logic        r_write_en;
    logic        r_busy;
    logic        r_halted;

    // Load or store seen in EXEC routes the instruction through MEM.
    logic        w_is_mem;
    // Halt is taken at WRITE if it was latched earlier or is requested now.
    logic        w_halt_now;
    // PC of the next instruction, valid while in WRITE.
    logic [31:0] w_next_pc;

    assign w_is_mem   = exec_is_load | exec_is_store;
    assign w_halt_now = r_halt | halt_req;
    assign w_next_pc  = r_jump_taken ? r_jump_dest : (r_pc + 32'd1);

    // Stage sequencing FSM: state, PC, latches and registered strobes.
    // Strobes are set on the edge that enters their state, so each one is
    // high for exactly the first cycle spent there.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_wait       <= 16'd0;
            r_halt       <= 1'b0;
            r_jump_taken <= 1'b0;
            r_jump_dest  <= 32'd0;
            r_fetch_en   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_exec_en    <= 1'b0;
            r_write_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_write_en  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_pc       <= RESET_PC;
                        r_wait     <= 16'd0;
                        r_fetch_en <= 1'b1;
                        r_busy     <= 1'b1;
                        // Start wins over a simultaneous halt, but the
                        // halt is kept so exactly one instruction runs.
                        if (halt_req) begin
                            r_halt <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    if (r_wait == FETCH_LAST) begin
                        r_state     <= ST_DECODE;
                        r_wait      <= 16'd0;
                        r_decode_en <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                ST_DECODE: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    r_state   <= ST_EXEC;
                    r_exec_en <= 1'b1;
                end
                ST_EXEC: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    r_jump_taken <= exec_is_jump;
                    r_jump_dest  <= exec_jump_dest;
                    r_wait       <= 16'd0;
                    if (w_is_mem) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state    <= ST_WRITE;
                        r_write_en <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    if (r_wait == MEM_LAST) begin
                        r_state    <= ST_WRITE;
                        r_wait     <= 16'd0;
                        r_write_en <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                ST_WRITE: begin
                    // PC only moves here, so it is stable for the whole
                    // FETCH..WRITE span of an instruction.
                    r_pc   <= w_next_pc;
                    r_wait <= 16'd0;
                    if (w_halt_now) begin
                        r_state  <= ST_HALTED;
                        r_halt   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_fetch_en <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // Resume at the held PC; halt_req has no effect here.
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_wait     <= 16'd0;
                        r_fetch_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign fetch_en  = r_fetch_en;
    assign decode_en = r_decode_en;
    assign exec_en   = r_exec_en;
    assign write_en  = r_write_en;
    assign busy      = r_busy;
    assign halted    = r_halted;

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_retired_count;

    // Performance counters: busy cycles and retired instructions; both wrap
    // and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cycle_count   <= 32'd0;
            r_retired_count <= 32'd0;
        end else begin
            if (r_busy) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (r_state == ST_WRITE) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;
`else
    assign cycle_count   = 32'h0;
    assign retired_count = 32'h0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: table of instruction vectors run
// back to back, a scoreboard of expected write-back timing / next PC, and a
// few hand-written sequences for reset-in-MEM and start+halt in IDLE.

module tb_core_sequencer;

    localparam int unsigned FETCH_LAT = 1;
    localparam int unsigned MEM_LAT   = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        exec_is_load = 1'b0;
    logic        exec_is_store = 1'b0;
    logic        exec_is_jump = 1'b0;
    logic [31:0] exec_jump_dest = 32'h0;
    logic [31:0] pc;
    logic        fetch_en, decode_en, exec_en, write_en, busy, halted;
    logic [31:0] cycle_count, retired_count;

    core_sequencer #(
        .FETCH_LAT(FETCH_LAT),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .halt_req      (halt_req),
        .exec_is_load  (exec_is_load),
        .exec_is_store (exec_is_store),
        .exec_is_jump  (exec_is_jump),
        .exec_jump_dest(exec_jump_dest),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .exec_en       (exec_en),
        .write_en      (write_en),
        .busy          (busy),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic        jmp;
        logic [31:0] dest;
        logic        hreq;      // pulse halt_req during DECODE
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic        exp_halt;  // core expected to halt after this one
    } vec_t;

    typedef struct {
        int          wr_idx;
        logic [31:0] next_pc;
        logic        halt;
    } sb_t;

    vec_t vecs[17];
    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic ld, logic st, logic jmp, logic [31:0] dest,
                                logic hreq, logic [31:0] epc, logic [31:0] enext,
                                logic ehalt);
        vec_t v;
        v.ld = ld; v.st = st; v.jmp = jmp; v.dest = dest; v.hreq = hreq;
        v.exp_pc = epc; v.exp_next = enext; v.exp_halt = ehalt;
        return v;
    endfunction

    // Entered at the negedge of the cycle where fetch_en should be high;
    // returns at the negedge of the cycle after write_en.
    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        int   t_dec, t_exe, t_wr, n_on;
        int   exp_len;
        sb_t  e;
        exp_len = int'(FETCH_LAT) + 3 + ((v.ld | v.st) ? int'(MEM_LAT) : 0);
        t_dec = -1; t_exe = -1; t_wr = -1; k = 0;
        chk("fetch_en", {31'd0, fetch_en}, 32'd1);
        chk("pc_at_fetch", pc, v.exp_pc);
        chk("busy_at_fetch", {31'd0, busy}, 32'd1);
        while (t_wr < 0 && k < 20) begin
            @(negedge clk);
            k++;
            n_on = int'(fetch_en) + int'(decode_en) + int'(exec_en) + int'(write_en);
            chk("onehot", (n_on > 1) ? 32'd1 : 32'd0, 32'd0);
            chk("pc_stable", pc, v.exp_pc);
            halt_req = (decode_en && v.hreq) ? 1'b1 : 1'b0;
            if (decode_en) t_dec = k;
            if (exec_en) begin
                t_exe = k;
                exec_is_load   = v.ld;
                exec_is_store  = v.st;
                exec_is_jump   = v.jmp;
                exec_jump_dest = v.dest;
                e.wr_idx  = exp_len - 1;
                e.next_pc = v.jmp ? v.dest : v.exp_pc + 32'd1;
                e.halt    = v.exp_halt;
                sb_q.push_back(e);
            end else begin
                exec_is_load = 1'b0; exec_is_store = 1'b0;
                exec_is_jump = 1'b0; exec_jump_dest = 32'h0;
            end
            if (write_en) t_wr = k;
        end
        halt_req = 1'b0;
        chk("decode_idx", t_dec, FETCH_LAT);
        chk("exec_idx", t_exe, FETCH_LAT + 1);
        if (t_wr < 0 || sb_q.size() == 0) begin
            chk("write_seen", 32'd0, 32'd1);
            sb_q.delete();
            e.wr_idx = exp_len - 1; e.next_pc = v.exp_next; e.halt = v.exp_halt;
        end else begin
            e = sb_q.pop_front();
            chk("write_idx", t_wr, e.wr_idx);
        end
        chk("sb_next_pc", e.next_pc, v.exp_next);
        @(negedge clk);
        chk("next_pc", pc, e.next_pc);
        chk("halted", {31'd0, halted}, {31'd0, e.halt});
        chk("busy", {31'd0, busy}, {31'd0, ~e.halt});
        chk("fetch_next", {31'd0, fetch_en}, {31'd0, ~e.halt});
        $display("vec %0d: pc=%h len=%0d next=%h halted=%0b", idx, v.exp_pc,
                 t_wr + 1, pc, halted);
    endtask

    task automatic pulse_start(input logic with_halt);
        start = 1'b1;
        halt_req = with_halt;
        @(negedge clk);
        start = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_strobes"}, {28'd0, fetch_en, decode_en, exec_en, write_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        int k, n_wr;
        // Phase A: run from reset, halt pulse in DECODE of the last one.
        vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h1,        0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h1,        32'h2,        0);
        vecs[2]  = mk(1, 0, 0, 32'h0,        0, 32'h2,        32'h3,        0);
        vecs[3]  = mk(0, 1, 0, 32'h0,        0, 32'h3,        32'h4,        0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h4,        32'h5,        0);
        vecs[5]  = mk(0, 0, 1, 32'h40,       0, 32'h5,        32'h40,       0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h40,       32'h41,       0);
        vecs[7]  = mk(1, 0, 1, 32'h5,        0, 32'h41,       32'h5,        0);
        vecs[8]  = mk(0, 0, 0, 32'h40,       0, 32'h5,        32'h6,        0);
        vecs[9]  = mk(0, 0, 0, 32'h0,        1, 32'h6,        32'h7,        1);
        // Phase B: resume from HALTED, PC wrap.
        vecs[10] = mk(0, 0, 1, 32'hFFFFFFFF, 0, 32'h7,        32'hFFFFFFFF, 0);
        vecs[11] = mk(0, 0, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0,        0);
        vecs[12] = mk(0, 0, 0, 32'h0,        1, 32'h0,        32'h1,        1);
        // Phase C: three plain instructions after reset, then halt.
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h1,        0);
        vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h1,        32'h2,        0);
        vecs[15] = mk(0, 0, 0, 32'h0,        1, 32'h2,        32'h3,        1);
        // Phase D: start and halt together in IDLE -> one instruction.
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h1,        1);

        @(negedge clk);
        do_reset();
        chk_idle_outputs("reset");
        chk("reset_cycles", cycle_count, 32'd0);
        chk("reset_retired", retired_count, 32'd0);

        pulse_start(1'b0);
        for (int i = 0; i <= 9; i++) run_vec(i, vecs[i]);

        // Halted: start a few cycles later resumes at the held PC.
        repeat (3) @(negedge clk);
        chk("halted_hold_pc", pc, 32'h7);
        chk("halted_flag", {31'd0, halted}, 32'd1);
        pulse_start(1'b0);
        for (int i = 10; i <= 12; i++) run_vec(i, vecs[i]);

        // Reset asserted during MEM abandons the load.
        pulse_start(1'b0);
        chk("mem_rst_fetch_pc", pc, 32'h1);
        k = 0;
        while (!exec_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("mem_rst_exec_seen", {31'd0, exec_en}, 32'd1);
        exec_is_load = 1'b1;
        @(negedge clk);
        exec_is_load = 1'b0;
        chk("mem_rst_no_strobe", {28'd0, fetch_en, decode_en, exec_en, write_en}, 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mem_rst");
        rstn = 1'b1;
        n_wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (write_en || busy) n_wr++;
        end
        chk("mem_rst_no_write", n_wr, 32'd0);
        $display("mem-reset: pc=%h busy=%0b", pc, busy);

        pulse_start(1'b0);
        for (int i = 13; i <= 15; i++) run_vec(i, vecs[i]);
`ifdef CORE_SEQ_PERF_EN
        chk("perf_retired", retired_count, 32'd3);
        chk("perf_cycles", cycle_count, 32'd12);
`else
        chk("perf_retired", retired_count, 32'd0);
        chk("perf_cycles", cycle_count, 32'd0);
`endif
        $display("perf: retired=%0d cycles=%0d", retired_count, cycle_count);

        do_reset();
        chk_idle_outputs("reset2");
        pulse_start(1'b1);
        run_vec(16, vecs[16]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle stage controller for the RV32I core. Owns the word-addressed PC and generates one-cycle enable strobes for the fetch, decode, execute and write-back stages in strict sequence. Inserts wait cycles for fetch and load/store memory latency, and selects the next PC from the execute stage's jump result. Sits at core top level, beside the stage modules, and drives their `enabled` inputs.

Parameters:
FETCH_LAT, 1, cycles spent in FETCH per instruction (>=1)
MEM_LAT, 2, cycles spent in MEM for load/store instructions (>=1)
RESET_PC, 32'h0, PC loaded on start from IDLE (word address)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  begin/resume execution; honoured in IDLE and HALTED only
halt_req  in  1  request stop after current instruction retires; sticky once sampled
exec_is_load  in  1  decoded instr is load; sampled in EXEC
exec_is_store  in  1  decoded instr is store; sampled in EXEC
exec_is_jump  in  1  execute stage jump taken; sampled in EXEC
exec_jump_dest  in  32  execute stage jump target (word address); sampled in EXEC
pc  out  32  current instruction PC (word address)
fetch_en  out  1  fetch stage enable strobe
decode_en  out  1  decode stage enable strobe
exec_en  out  1  execute stage enable strobe
write_en  out  1  write-back stage enable strobe
busy  out  1  high in every state except IDLE and HALTED
halted  out  1  high in HALTED
cycle_count  out  32  cycles spent outside IDLE/HALTED (see optional feature)
retired_count  out  32  instructions retired (see optional feature)

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, pc=RESET_PC, halt latch=0, jump latches=0, wait counter=0, counters=0.
  - All enables, busy and halted are 0.
  - Reset mid-instruction abandons it; no strobe is emitted in the reset cycle.
- Enables, busy and halted decode from the state register only. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: start=1 -> FETCH, pc<=RESET_PC.
  - FETCH: fetch_en=1 in first FETCH cycle only. Stays FETCH_LAT cycles, then -> DECODE.
  - DECODE: decode_en=1 for 1 cycle -> EXEC.
  - EXEC: exec_en=1 for 1 cycle.
    - Latch jump_taken<=exec_is_jump and jump_dest<=exec_jump_dest.
    - exec_is_load|exec_is_store -> MEM, else -> WRITE.
  - MEM: no strobes. Stays MEM_LAT cycles -> WRITE.
  - WRITE: write_en=1 for 1 cycle.
    - pc<=jump_taken ? jump_dest : pc+1 (mod 2^32; pc=32'hFFFFFFFF wraps to 0).
    - retired_count+1.
    - If halt latch (or halt_req this cycle) -> HALTED, clear halt latch; else -> FETCH.
  - HALTED: pc held. start=1 -> FETCH, resuming at held pc; halt_req ignored.
- At most one enable is high in any cycle.
- Latency:
  - Non-memory instruction = FETCH_LAT+3 cycles (4 at default).
  - Load/store instruction = FETCH_LAT+MEM_LAT+3 cycles.
- halt_req is sampled in every busy state. A 1-cycle pulse anywhere in an instruction halts after that instruction's WRITE.
- start while busy: ignored. start and halt_req together in IDLE: start wins, and the halt is latched, so the core halts after one instruction.
- pc is stable from FETCH through WRITE; it updates only on the WRITE->next edge.

Optional Feature:
CORE_SEQ_PERF_EN
- Defined:
  - cycle_count increments every cycle busy=1.
  - retired_count increments on each WRITE cycle.
  - Both are 32-bit, wrap at 2^32, cleared only by reset, and held in IDLE/HALTED.
- Undefined: both outputs are tied to 32'h0 and no counter flops are synthesized.

Test Plan:
- Reset with defaults, start pulse, all exec_* inputs=0:
  - fetch_en at cycle 1, decode_en at 2, exec_en at 3, write_en at 4.
  - pc advances 0->1->2 at 4-cycle spacing.
- exec_is_load=1 in EXEC, MEM_LAT=2: two cycles with no strobe between exec_en and write_en; instruction takes 6 cycles; pc 0->1.
- exec_is_jump=1, exec_jump_dest=32'h40 in EXEC of pc=5: next fetch_en occurs with pc=32'h40. The same with exec_is_jump=0 gives pc=6.
- halt_req 1-cycle pulse during DECODE:
  - write_en still fires, then halted=1, busy=0, pc=next PC.
  - A later start resumes at that PC.
- rstn=0 asserted during MEM: next cycle state=IDLE, pc=RESET_PC, all strobes 0, and no write_en is produced for the abandoned instruction.
- With CORE_SEQ_PERF_EN, 3 non-memory instructions then halt: retired_count=3 and cycle_count=12. Without the macro, both read 0.
